// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot loader.
package uart_boot_pkg;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_WRITE,
    S_ACK,
    S_DONE
  } boot_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a length-prefixed little-endian word image from
// the rx FIFO, writes it into instruction memory, sends one ACK byte, then
// hands both FIFO interfaces over to the cpu through a transparent mux.
module uart_boot_loader #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned BASE_ADDR = 0,
  parameter logic [7:0]  ACK_BYTE  = 8'hAA
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_dout,
  input  logic              rx_empty,
  output logic              rx_rd_en,
  output logic [7:0]        tx_din,
  input  logic              tx_full,
  output logic              tx_wr_en,
  input  logic              cpu_rd_en,
  output logic              cpu_rx_empty,
  input  logic [7:0]        cpu_tx_din,
  input  logic              cpu_wr_en,
  output logic              cpu_tx_full,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              boot_done
);

  import uart_boot_pkg::*;

  boot_state_t       state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_cnt_q, word_cnt_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       shift_q, shift_d;
  logic              boot_done_q, boot_done_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              last_byte;
  logic [31:0]       len_full;
  logic [31:0]       word_full;

  // State, counters and imem write port registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_LEN;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
      len_q        <= '0;
      shift_q      <= '0;
      boot_done_q  <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= ADDR_W'(BASE_ADDR);
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      len_q        <= len_d;
      shift_q      <= shift_d;
      boot_done_q  <= boot_done_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  // Next state, byte assembly and FIFO ownership mux.
  // The imem port is loaded on the 4th data byte so the registered strobe is
  // high exactly during the S_WRITE cycle.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    len_d        = len_q;
    shift_d      = shift_q;
    boot_done_d  = boot_done_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    last_byte    = (byte_cnt_q == 2'(BYTES_PER_WORD - 1));
    len_full     = {rx_dout, len_q[23:0]};
    word_full    = {rx_dout, shift_q[31:8]};

    rx_rd_en     = 1'b0;
    cpu_rx_empty = 1'b1;
    tx_din       = ACK_BYTE;
    tx_wr_en     = 1'b0;
    cpu_tx_full  = 1'b1;

    case (state_q)
      S_LEN: begin
        if (!rx_empty) begin
          rx_rd_en                       = 1'b1;
          len_d[{byte_cnt_q, 3'b000} +: 8] = rx_dout;
          byte_cnt_d                     = byte_cnt_q + 2'd1;
          if (last_byte) begin
            state_d = (len_full != '0) ? S_DATA : S_ACK;
          end
        end
      end
      S_DATA: begin
        if (!rx_empty) begin
          rx_rd_en   = 1'b1;
          shift_d    = word_full;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (last_byte) begin
            state_d      = S_WRITE;
            imem_we_d    = 1'b1;
            imem_addr_d  = ADDR_W'(BASE_ADDR) + word_cnt_q[ADDR_W-1:0];
            imem_wdata_d = word_full;
          end
        end
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_q + 32'd1;
        state_d    = ((word_cnt_q + 32'd1) == len_q) ? S_ACK : S_DATA;
      end
      S_ACK: begin
        if (!tx_full) begin
          tx_wr_en    = 1'b1;
          state_d     = S_DONE;
          boot_done_d = 1'b1;
        end
      end
      S_DONE: begin
        rx_rd_en     = cpu_rd_en;
        cpu_rx_empty = rx_empty;
        tx_din       = cpu_tx_din;
        tx_wr_en     = cpu_wr_en;
        cpu_tx_full  = tx_full;
      end
      default: state_d = S_LEN;
    endcase
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign boot_done  = boot_done_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: a default instance and an
// ADDR_W=2 instance share one rx FIFO model selected by 'sel'.
module tb_uart_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       tx_full = 1'b0;
  logic       cpu_rd_en = 1'b0;
  logic       cpu_wr_en = 1'b0;
  logic [7:0] cpu_tx_din = 8'h00;

  logic        rx_rd_en0, tx_wr_en0, cpu_rx_empty0, cpu_tx_full0, imem_we0, boot_done0;
  logic [7:0]  tx_din0;
  logic [13:0] imem_addr0;
  logic [31:0] imem_wdata0;
  logic        rx_rd_en1, tx_wr_en1, cpu_rx_empty1, cpu_tx_full1, imem_we1, boot_done1;
  logic [7:0]  tx_din1;
  logic [1:0]  imem_addr1;
  logic [31:0] imem_wdata1;

  logic rx_empty0, tx_full0, cpu_rd_en0, cpu_wr_en0, rx_empty1, tx_full1;
  assign rx_empty0  = sel ? 1'b1 : fifo_empty;
  assign tx_full0   = sel ? 1'b1 : tx_full;
  assign cpu_rd_en0 = sel ? 1'b0 : cpu_rd_en;
  assign cpu_wr_en0 = sel ? 1'b0 : cpu_wr_en;
  assign rx_empty1  = sel ? fifo_empty : 1'b1;
  assign tx_full1   = sel ? tx_full : 1'b1;

  uart_boot_loader dut0 (
    .clk(clk), .rstn(rstn), .rx_dout(fifo_dout), .rx_empty(rx_empty0), .rx_rd_en(rx_rd_en0),
    .tx_din(tx_din0), .tx_full(tx_full0), .tx_wr_en(tx_wr_en0), .cpu_rd_en(cpu_rd_en0),
    .cpu_rx_empty(cpu_rx_empty0), .cpu_tx_din(cpu_tx_din), .cpu_wr_en(cpu_wr_en0),
    .cpu_tx_full(cpu_tx_full0), .imem_we(imem_we0), .imem_addr(imem_addr0),
    .imem_wdata(imem_wdata0), .boot_done(boot_done0)
  );

  uart_boot_loader #(.ADDR_W(2), .BASE_ADDR(0), .ACK_BYTE(8'hAA)) dut1 (
    .clk(clk), .rstn(rstn), .rx_dout(fifo_dout), .rx_empty(rx_empty1), .rx_rd_en(rx_rd_en1),
    .tx_din(tx_din1), .tx_full(tx_full1), .tx_wr_en(tx_wr_en1), .cpu_rd_en(1'b0),
    .cpu_rx_empty(cpu_rx_empty1), .cpu_tx_din(8'h00), .cpu_wr_en(1'b0),
    .cpu_tx_full(cpu_tx_full1), .imem_we(imem_we1), .imem_addr(imem_addr1),
    .imem_wdata(imem_wdata1), .boot_done(boot_done1)
  );

  logic        rd_en_m, tx_wr_en_m, cpu_rx_empty_m, cpu_tx_full_m, imem_we_m, boot_done_m;
  logic [7:0]  tx_din_m;
  logic [13:0] imem_addr_m;
  logic [31:0] imem_wdata_m;
  assign rd_en_m        = sel ? rx_rd_en1 : rx_rd_en0;
  assign tx_wr_en_m     = sel ? tx_wr_en1 : tx_wr_en0;
  assign cpu_rx_empty_m = sel ? cpu_rx_empty1 : cpu_rx_empty0;
  assign cpu_tx_full_m  = sel ? cpu_tx_full1 : cpu_tx_full0;
  assign imem_we_m      = sel ? imem_we1 : imem_we0;
  assign boot_done_m    = sel ? boot_done1 : boot_done0;
  assign tx_din_m       = sel ? tx_din1 : tx_din0;
  assign imem_addr_m    = sel ? {12'b0, imem_addr1} : imem_addr0;
  assign imem_wdata_m   = sel ? imem_wdata1 : imem_wdata0;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
    int          gap;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  logic [7:0] rx_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_we = 0;
  int   done_due = -1;
  logic popped = 1'b0;
  logic gap_en = 1'b0;
  logic gap_tgl = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO model update on the falling edge, then the monitor samples 2ns later.
  always @(negedge clk) begin
    if (popped && rx_q.size() > 0) void'(rx_q.pop_front());
    popped     = 1'b0;
    gap_tgl    = ~gap_tgl;
    fifo_empty = (rx_q.size() == 0) || (gap_en && gap_tgl);
    fifo_dout  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    #2;
    cyc++;
    if (rstn) begin
      popped = rd_en_m && !fifo_empty;
      if (fifo_empty) check("rx_pop_when_empty", {31'b0, rd_en_m}, 32'd0);
      if (!boot_done_m) begin
        check("cpu_rx_empty_before_done", {31'b0, cpu_rx_empty_m}, 32'd1);
        check("cpu_tx_full_before_done", {31'b0, cpu_tx_full_m}, 32'd1);
      end
      if (done_due == cyc) begin
        check("boot_done_after_ack", {31'b0, boot_done_m}, 32'd1);
        done_due = -1;
      end
      if (imem_we_m) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_imem_we: got addr 0x%0h data 0x%0h expected no write", imem_addr_m, imem_wdata_m);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("imem_addr", {18'b0, imem_addr_m}, {18'b0, e.addr});
          check("imem_wdata", imem_wdata_m, e.data);
          if (e.gap != 0) check("imem_we_spacing", cyc - last_we, e.gap);
        end
        last_we = cyc;
      end
      if (tx_wr_en_m) begin
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx_push: got 0x%0h expected no push", tx_din_m);
        end else begin
          check("tx_din", {24'b0, tx_din_m}, {24'b0, exp_tx.pop_front()});
        end
        if (!boot_done_m) begin
          check("tx_push_while_full", {31'b0, tx_full}, 32'd0);
          done_due = cyc + 1;
        end
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) rx_q.push_back(w[8*i +: 8]);
  endtask

  task automatic exp_write(input logic [13:0] a, input logic [31:0] d, input int gap);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.gap  = gap;
    exp_wr.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    rx_q.delete();
    popped   = 1'b0;
    done_due = -1;
    repeat (3) @(negedge clk);
    check("rst_imem_we", {31'b0, imem_we_m}, 32'd0);
    check("rst_imem_addr", {18'b0, imem_addr_m}, 32'd0);
    check("rst_imem_wdata", imem_wdata_m, 32'd0);
    check("rst_boot_done", {31'b0, boot_done_m}, 32'd0);
    rstn = 1'b1;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!boot_done_m && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("boot_done_reached", {31'b0, boot_done_m}, 32'd1);
  endtask

  task automatic check_drained();
    repeat (3) @(negedge clk);
    check("imem_writes_outstanding", exp_wr.size(), 32'd0);
    check("tx_pushes_outstanding", exp_tx.size(), 32'd0);
  endtask

  initial begin
    // Len=2, back-to-back bytes.
    sel = 1'b0;
    tx_full = 1'b0;
    do_reset();
    exp_write(14'd0, 32'h0000_0013, 0);
    exp_write(14'd1, 32'hDEAD_BEEF, 5);
    exp_tx.push_back(8'hAA);
    push_word(32'd2);
    push_word(32'h0000_0013);
    push_word(32'hDEAD_BEEF);
    wait_done(100);
    check_drained();

    // Len=0: ACK only, trailing byte left for the cpu.
    do_reset();
    exp_tx.push_back(8'hAA);
    push_word(32'd0);
    rx_q.push_back(8'h55);
    wait_done(50);
    repeat (4) @(negedge clk);
    #2;
    check("len0_byte_left", rx_q.size(), 32'd1);
    check("cpu_rx_empty_after_done", {31'b0, cpu_rx_empty_m}, 32'd0);
    check("cpu_sees_byte", {24'b0, fifo_dout}, 32'h55);
    @(negedge clk);
    cpu_rd_en = 1'b1;
    @(negedge clk);
    cpu_rd_en = 1'b0;
    repeat (2) @(negedge clk);
    check("cpu_popped_byte", rx_q.size(), 32'd0);
    exp_tx.push_back(8'h3C);
    @(negedge clk);
    cpu_tx_din = 8'h3C;
    cpu_wr_en  = 1'b1;
    @(negedge clk);
    cpu_wr_en = 1'b0;
    tx_full   = 1'b1;
    #2;
    check("cpu_tx_full_follows_1", {31'b0, cpu_tx_full_m}, 32'd1);
    @(negedge clk);
    tx_full = 1'b0;
    #2;
    check("cpu_tx_full_follows_0", {31'b0, cpu_tx_full_m}, 32'd0);
    check_drained();

    // Gapped rx, tx_full held in S_ACK, cpu requests ignored.
    do_reset();
    gap_en  = 1'b1;
    tx_full = 1'b1;
    exp_write(14'd0, 32'h0000_0013, 0);
    exp_write(14'd1, 32'hDEAD_BEEF, 0);
    push_word(32'd2);
    push_word(32'h0000_0013);
    push_word(32'hDEAD_BEEF);
    begin
      int n = 0;
      while (exp_wr.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    check("gapped_writes_seen", exp_wr.size(), 32'd0);
    rx_q.push_back(8'h77);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cpu_rd_en  = i[0];
      cpu_wr_en  = ~i[0];
      cpu_tx_din = 8'h11;
    end
    @(negedge clk);
    cpu_rd_en = 1'b0;
    cpu_wr_en = 1'b0;
    check("no_done_while_tx_full", {31'b0, boot_done_m}, 32'd0);
    check("cpu_pop_ignored", rx_q.size(), 32'd1);
    exp_tx.push_back(8'hAA);
    tx_full = 1'b0;
    wait_done(20);
    gap_en = 1'b0;
    check_drained();

    // ADDR_W=2: five words wrap onto address 0.
    @(negedge clk);
    sel = 1'b1;
    do_reset();
    exp_write(14'd0, 32'd1, 0);
    exp_write(14'd1, 32'd2, 5);
    exp_write(14'd2, 32'd3, 5);
    exp_write(14'd3, 32'd4, 5);
    exp_write(14'd0, 32'd5, 5);
    exp_tx.push_back(8'hAA);
    push_word(32'd5);
    for (int w = 1; w <= 5; w++) push_word(32'(w));
    wait_done(200);
    check_drained();

    // Reset mid-load, then cpu requests before boot_done, then a clean load.
    @(negedge clk);
    sel = 1'b0;
    do_reset();
    push_word(32'd1);
    rx_q.push_back(8'h99);
    rx_q.push_back(8'h88);
    begin
      int n = 0;
      while (rx_q.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("partial_bytes_consumed", rx_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cpu_rd_en  = 1'b1;
      cpu_wr_en  = 1'b1;
      cpu_tx_din = 8'h22;
    end
    @(negedge clk);
    cpu_rd_en = 1'b0;
    cpu_wr_en = 1'b0;
    exp_write(14'd0, 32'h1234_5678, 0);
    exp_tx.push_back(8'hAA);
    push_word(32'd1);
    push_word(32'h1234_5678);
    wait_done(100);
    check_drained();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish before 200000ns");
    $fatal(1, "timeout");
  end

endmodule
